// File: rtl/tdp_arb_pkg.sv
// rtl/tdp_arb_pkg.sv - shared types and helpers for the BRAM port arbiter
package tdp_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    localparam int ID_W = 1;

    // Read latency seen by the tag pipe: one BRAM cycle plus the optional output register.
    function automatic int rd_lat(input int output_reg);
        return 1 + output_reg;
    endfunction

endpackage

// File: rtl/tdp_rd_tag_pipe.sv
// rtl/tdp_rd_tag_pipe.sv - shift register of {valid, id} tags producing per-requester read valids
module tdp_rd_tag_pipe
    import tdp_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid_0,
    output logic            out_valid_1
);

    logic [DEPTH-1:0]           vld_q, vld_d;
    logic [DEPTH-1:0][ID_W-1:0] id_q, id_d;

    always_comb begin
        vld_d    = '0;
        id_d     = '0;
        vld_d[0] = in_valid;
        id_d[0]  = in_id;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    assign out_valid_0 = vld_q[DEPTH-1] && (id_q[DEPTH-1] == '0);
    assign out_valid_1 = vld_q[DEPTH-1] && (id_q[DEPTH-1] != '0);

endmodule

// File: rtl/tdp_port_arbiter.sv
// rtl/tdp_port_arbiter.sv - round-robin share of one BRAM port between two requesters with post-reset clear sweep
module tdp_port_arbiter
    import tdp_arb_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 4,
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    BYTEEN_WIDTH = 2,
    parameter int                    OUTPUT_REG   = 1,
    parameter int                    INIT_EN      = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid_0,
    input  logic                    req_valid_1,
    output logic                    req_ready_0,
    output logic                    req_ready_1,
    input  logic                    req_we_0,
    input  logic                    req_we_1,
    input  logic [ADDR_WIDTH-1:0]   req_addr_0,
    input  logic [ADDR_WIDTH-1:0]   req_addr_1,
    input  logic [DATA_WIDTH-1:0]   req_wdata_0,
    input  logic [DATA_WIDTH-1:0]   req_wdata_1,
    input  logic [BYTEEN_WIDTH-1:0] req_byteen_0,
    input  logic [BYTEEN_WIDTH-1:0] req_byteen_1,
    output logic                    rsp_valid_0,
    output logic                    rsp_valid_1,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    init_done,
    output logic                    bram_clke,
    output logic                    bram_we,
    output logic [BYTEEN_WIDTH-1:0] bram_byteen,
    output logic                    bram_addren,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic [DATA_WIDTH-1:0]   bram_wdata,
    input  logic [DATA_WIDTH-1:0]   bram_rdata
);

    localparam int                    RD_LAT   = rd_lat(OUTPUT_REG);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    arb_state_t                state_q, state_d;
    logic [ID_W-1:0]           rr_q, rr_d;
    logic [ADDR_WIDTH-1:0]     init_addr_q, init_addr_d;
    logic                      init_last_q, init_last_d;
    logic                      init_done_q, init_done_d;
    logic                      clke_q, clke_d, we_q, we_d, addren_q, addren_d;
    logic [BYTEEN_WIDTH-1:0]   byteen_q, byteen_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      rd_issue_q, rd_issue_d;
    logic [ID_W-1:0]           rd_id_q, rd_id_d;

    logic                      grant_0, grant_1;
    logic                      sel_we;
    logic [ADDR_WIDTH-1:0]     sel_addr;
    logic [DATA_WIDTH-1:0]     sel_wdata;
    logic [BYTEEN_WIDTH-1:0]   sel_byteen;

    // Requesters are only served once the sweep has completed.
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (state_q == ST_RUN && init_done_q) begin
            if (req_valid_0 && (!req_valid_1 || rr_q == '0)) grant_0 = 1'b1;
            else if (req_valid_1)                             grant_1 = 1'b1;
        end
        sel_we     = grant_1 ? req_we_1     : req_we_0;
        sel_addr   = grant_1 ? req_addr_1   : req_addr_0;
        sel_wdata  = grant_1 ? req_wdata_1  : req_wdata_0;
        sel_byteen = grant_1 ? req_byteen_1 : req_byteen_0;
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        init_addr_d = init_addr_q;
        init_last_d = init_last_q;
        init_done_d = init_done_q;
        clke_d      = 1'b0;
        we_d        = 1'b0;
        addren_d    = 1'b0;
        byteen_d    = '0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_issue_d  = 1'b0;
        rd_id_d     = '0;
        case (state_q)
            ST_INIT: begin
                if (init_last_q) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                    init_last_d = 1'b0;
                end else begin
                    clke_d      = 1'b1;
                    addren_d    = 1'b1;
                    we_d        = 1'b1;
                    byteen_d    = '1;
                    addr_d      = init_addr_q;
                    wdata_d     = INIT_VALUE;
                    init_addr_d = init_addr_q + 1'b1;
                    init_last_d = (init_addr_q == ADDR_MAX);
                end
            end
            default: begin
                init_done_d = 1'b1;
                if (grant_0 || grant_1) begin
                    clke_d     = 1'b1;
                    addren_d   = 1'b1;
                    we_d       = sel_we;
                    byteen_d   = sel_we ? sel_byteen : '0;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    rd_issue_d = !sel_we;
                    rd_id_d    = grant_1 ? ID_W'(1) : '0;
                    rr_d       = grant_0 ? ID_W'(1) : '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            rr_q        <= '0;
            init_addr_q <= '0;
            init_last_q <= 1'b0;
            init_done_q <= 1'b0;
            clke_q      <= 1'b0;
            we_q        <= 1'b0;
            addren_q    <= 1'b0;
            byteen_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_issue_q  <= 1'b0;
            rd_id_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            init_addr_q <= init_addr_d;
            init_last_q <= init_last_d;
            init_done_q <= init_done_d;
            clke_q      <= clke_d;
            we_q        <= we_d;
            addren_q    <= addren_d;
            byteen_q    <= byteen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_issue_q  <= rd_issue_d;
            rd_id_q     <= rd_id_d;
        end
    end

    // Tags enter when the read is on the BRAM pins, so the pipe depth equals the BRAM read latency.
    tdp_rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (rd_issue_q),
        .in_id       (rd_id_q),
        .out_valid_0 (rsp_valid_0),
        .out_valid_1 (rsp_valid_1)
    );

    assign req_ready_0 = grant_0;
    assign req_ready_1 = grant_1;
    assign rsp_rdata   = bram_rdata;
    assign init_done   = init_done_q;
    assign bram_clke   = clke_q;
    assign bram_we     = we_q;
    assign bram_byteen = byteen_q;
    assign bram_addren = addren_q;
    assign bram_addr   = addr_q;
    assign bram_wdata  = wdata_q;

endmodule

// File: tb/tb_tdp_port_arbiter.sv
// tb/tb_tdp_port_arbiter.sv - self-checking bench for tdp_port_arbiter
module tb_tdp_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0, req_we_0 = 1'b0, req_we_1 = 1'b0;
    logic [3:0]  req_addr_0 = '0, req_addr_1 = '0;
    logic [15:0] req_wdata_0 = '0, req_wdata_1 = '0;
    logic [1:0]  req_byteen_0 = '0, req_byteen_1 = '0;

    logic        a_rdy0, a_rdy1, a_rsp0, a_rsp1, a_done, a_clke, a_we, a_addren;
    logic [1:0]  a_be;
    logic [3:0]  a_addr;
    logic [15:0] a_wdata, a_rdata_o, a_rdata_i;
    logic        b_rdy0, b_rdy1, b_rsp0, b_rsp1, b_done, b_clke, b_we, b_addren;
    logic [1:0]  b_be;
    logic [3:0]  b_addr;
    logic [15:0] b_wdata, b_rdata_o, b_rdata_i;

    localparam logic [15:0] INIT_A = 16'h0000;
    localparam logic [15:0] INIT_B = 16'hC3A5;

    always #5 clk = ~clk;

    tdp_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTEEN_WIDTH(2), .OUTPUT_REG(0),
                       .INIT_EN(1), .INIT_VALUE(INIT_A)) u_a (
        .clk(clk), .rstn(rstn),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(a_rdy0), .req_ready_1(a_rdy1),
        .req_we_0(req_we_0), .req_we_1(req_we_1),
        .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
        .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
        .req_byteen_0(req_byteen_0), .req_byteen_1(req_byteen_1),
        .rsp_valid_0(a_rsp0), .rsp_valid_1(a_rsp1), .rsp_rdata(a_rdata_o),
        .init_done(a_done), .bram_clke(a_clke), .bram_we(a_we), .bram_byteen(a_be),
        .bram_addren(a_addren), .bram_addr(a_addr), .bram_wdata(a_wdata), .bram_rdata(a_rdata_i)
    );

    tdp_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTEEN_WIDTH(2), .OUTPUT_REG(1),
                       .INIT_EN(1), .INIT_VALUE(INIT_B)) u_b (
        .clk(clk), .rstn(rstn),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(b_rdy0), .req_ready_1(b_rdy1),
        .req_we_0(req_we_0), .req_we_1(req_we_1),
        .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
        .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
        .req_byteen_0(req_byteen_0), .req_byteen_1(req_byteen_1),
        .rsp_valid_0(b_rsp0), .rsp_valid_1(b_rsp1), .rsp_rdata(b_rdata_o),
        .init_done(b_done), .bram_clke(b_clke), .bram_we(b_we), .bram_byteen(b_be),
        .bram_addren(b_addren), .bram_addr(b_addr), .bram_wdata(b_wdata), .bram_rdata(b_rdata_i)
    );

    // BRAM models: a without, b with output register.
    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];
    logic [15:0] ra_q, rb_q, rb_q2;

    always @(posedge clk) begin
        if (a_clke && a_addren) begin
            if (a_we && a_be[0]) mem_a[a_addr][7:0]  <= a_wdata[7:0];
            if (a_we && a_be[1]) mem_a[a_addr][15:8] <= a_wdata[15:8];
            ra_q <= mem_a[a_addr];
        end
        if (b_clke && b_addren) begin
            if (b_we && b_be[0]) mem_b[b_addr][7:0]  <= b_wdata[7:0];
            if (b_we && b_be[1]) mem_b[b_addr][15:8] <= b_wdata[15:8];
            rb_q <= mem_b[b_addr];
        end
        rb_q2 <= rb_q;
    end
    assign a_rdata_i = ra_q;
    assign b_rdata_i = rb_q2;

    // Reference model: array contents, round-robin owner, expected responses by due cycle.
    typedef struct {
        int          due;
        int          id;
        logic [15:0] data;
    } rsp_t;

    logic [15:0] ref_a [16];
    logic [15:0] ref_b [16];
    rsp_t        q_a[$];
    rsp_t        q_b[$];
    int          rr;
    int          cyc;
    int          checks;
    int          errors;
    logic        iss_v, iss_we;
    logic [3:0]  iss_a;
    logic [15:0] iss_d;
    logic [1:0]  iss_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = d[7:0];
        if (be[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    task automatic check_reset();
        chk("rst_ready", {a_rdy0, a_rdy1, b_rdy0, b_rdy1}, 0);
        chk("rst_rsp", {a_rsp0, a_rsp1, b_rsp0, b_rsp1}, 0);
        chk("rst_done", {a_done, b_done}, 0);
        chk("rst_ctl", {a_clke, a_we, a_addren, b_clke, b_we, b_addren}, 0);
        chk("rst_be", {a_be, b_be}, 0);
        chk("rst_addr", {a_addr, b_addr}, 0);
        chk("rst_wdata", {a_wdata, b_wdata}, 0);
    endtask

    task automatic check_init();
        req_valid_0 = 1'b1;
        req_valid_1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ref_a[i] = INIT_A;
            ref_b[i] = INIT_B;
        end
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("init_ctl", {a_clke, a_addren, a_we, b_clke, b_we}, 5'b11111);
            chk("init_addr", a_addr, i);
            chk("init_addr_b", b_addr, i);
            chk("init_be", a_be, 2'b11);
            chk("init_wdata_a", a_wdata, INIT_A);
            chk("init_wdata_b", b_wdata, INIT_B);
            chk("init_ready", {a_rdy0, a_rdy1, b_rdy0, b_rdy1}, 0);
            chk("init_done_low", {a_done, b_done}, 0);
        end
        @(posedge clk);
        #1;
        iss_v = 1'b0;
        rr    = 0;
    endtask

    task automatic do_cycle(input logic v0, input logic w0, input logic [3:0] a0, input logic [15:0] d0,
                            input logic [1:0] b0, input logic v1, input logic w1, input logic [3:0] a1,
                            input logic [15:0] d1, input logic [1:0] b1);
        int          win;
        logic        we;
        logic [3:0]  ad;
        logic [15:0] dd;
        logic [1:0]  be;
        req_valid_0 = v0; req_we_0 = w0; req_addr_0 = a0; req_wdata_0 = d0; req_byteen_0 = b0;
        req_valid_1 = v1; req_we_1 = w1; req_addr_1 = a1; req_wdata_1 = d1; req_byteen_1 = b1;
        @(negedge clk);
        win = -1;
        if (v0 && v1) win = rr;
        else if (v0)  win = 0;
        else if (v1)  win = 1;
        chk("init_done", {a_done, b_done}, 2'b11);
        chk("ready_0", a_rdy0, win == 0);
        chk("ready_1", a_rdy1, win == 1);
        chk("b_ready", {b_rdy0, b_rdy1}, {win == 0, win == 1});
        chk("bram_clke", {a_clke, a_addren, b_clke}, {3{iss_v}});
        chk("bram_we", a_we, iss_v && iss_we);
        chk("bram_byteen", a_be, (iss_v && iss_we) ? iss_b : 2'b00);
        if (iss_v) chk("bram_addr", a_addr, iss_a);
        if (iss_v && iss_we) chk("bram_wdata", a_wdata, iss_d);
        chk("a_rsp_valid_0", a_rsp0, q_a.size() > 0 && q_a[0].due == cyc && q_a[0].id == 0);
        chk("a_rsp_valid_1", a_rsp1, q_a.size() > 0 && q_a[0].due == cyc && q_a[0].id == 1);
        if (q_a.size() > 0 && q_a[0].due == cyc) begin
            chk("a_rsp_rdata", a_rdata_o, q_a[0].data);
            void'(q_a.pop_front());
        end
        chk("b_rsp_valid_0", b_rsp0, q_b.size() > 0 && q_b[0].due == cyc && q_b[0].id == 0);
        chk("b_rsp_valid_1", b_rsp1, q_b.size() > 0 && q_b[0].due == cyc && q_b[0].id == 1);
        if (q_b.size() > 0 && q_b[0].due == cyc) begin
            chk("b_rsp_rdata", b_rdata_o, q_b[0].data);
            void'(q_b.pop_front());
        end
        iss_v = (win >= 0);
        if (win >= 0) begin
            we = (win == 0) ? w0 : w1;
            ad = (win == 0) ? a0 : a1;
            dd = (win == 0) ? d0 : d1;
            be = (win == 0) ? b0 : b1;
            iss_we = we; iss_a = ad; iss_d = dd; iss_b = be;
            if (we) begin
                ref_a[ad] = merge(ref_a[ad], dd, be);
                ref_b[ad] = merge(ref_b[ad], dd, be);
            end else begin
                q_a.push_back('{due: cyc + 2, id: win, data: ref_a[ad]});
                q_b.push_back('{due: cyc + 3, id: win, data: ref_b[ad]});
            end
            rr = 1 - win;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rr     = 0;
        iss_v  = 1'b0;
        req_valid_0 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check_init();

        // Contention directly after the sweep, then requester 1 alone.
        for (int i = 0; i < 8; i++)
            do_cycle(1, 1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom),
                     1, 1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom));
        for (int i = 0; i < 4; i++)
            do_cycle(0, 0, 0, 0, 0, 1, 1'($urandom), 4'($urandom), 16'($urandom), 2'b11);
        idle(4);

        // Full write then read, partial write then read.
        do_cycle(1, 1, 4'd3, 16'h1234, 2'b11, 0, 0, 0, 0, 0);
        do_cycle(1, 0, 4'd3, 16'h0000, 2'b00, 0, 0, 0, 0, 0);
        idle(4);
        do_cycle(0, 0, 0, 0, 0, 1, 1, 4'd3, 16'hAB00, 2'b10);
        do_cycle(0, 0, 0, 0, 0, 1, 0, 4'd3, 16'h0000, 2'b00);
        idle(4);

        // Streaming reads.
        for (int i = 0; i < 4; i++) do_cycle(1, 1, 4'(i), 16'h0010 + 16'(i), 2'b11, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, 0, 0, 1, 0, 4'(i), 0, 0);
        idle(4);

        for (int i = 0; i < 200; i++)
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom),
                     1'($urandom_range(0, 1)), 1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom));
        idle(4);

        // Reset one cycle after a read accept: the read must never return.
        do_cycle(1, 0, 4'd5, 0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b0;
        #1;
        check_reset();
        q_a.delete();
        q_b.delete();
        iss_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset();
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check_init();
        idle(4);
        do_cycle(0, 0, 0, 0, 0, 1, 0, 4'd5, 0, 0);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
